// File: rtl/paula_audio_pkg.sv
// Shared types and constants for the Paula audio mixer sequencer.
package paula_audio_pkg;

  localparam int unsigned NUM_CH   = 4;
  localparam int unsigned SMP_W    = 8;
  localparam int unsigned VOL_W    = 7;
  localparam int unsigned MIX_W    = 15;
  localparam int unsigned PROD_W   = MIX_W + 1;
  localparam int unsigned VOL_FULL = 64;

  // Bit k set routes channel k to the left mix, clear routes it right.
  localparam logic [NUM_CH-1:0] LR_ROUTE = 4'b1001;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL0 = 3'd1,
    ST_MUL1 = 3'd2,
    ST_MUL2 = 3'd3,
    ST_MUL3 = 3'd4,
    ST_DONE = 3'd5
  } mix_state_e;

  typedef struct packed {
    logic [NUM_CH*SMP_W-1:0] smp;
    logic [NUM_CH*VOL_W-1:0] vol;
    logic [NUM_CH-1:0]       mask;
  } mix_snap_t;

  // Channel served by the shared multiplier in a given sequencer state.
  function automatic logic [1:0] chan_of(input mix_state_e s);
    case (s)
      ST_MUL1: chan_of = 2'd1;
      ST_MUL2: chan_of = 2'd2;
      ST_MUL3: chan_of = 2'd3;
      default: chan_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/paula_audio_mixseq_if.sv
// Sample/volume inputs and mixed outputs of the audio mixer sequencer.
interface paula_audio_mixseq_if;
  import paula_audio_pkg::*;

  logic [NUM_CH*SMP_W-1:0] aud_smp;
  logic [NUM_CH*VOL_W-1:0] aud_vol;
  logic [NUM_CH-1:0]       aud_mask;
  logic [NUM_CH-1:0]       chan_ack;
  logic signed [MIX_W-1:0] ldatasum;
  logic signed [MIX_W-1:0] rdatasum;
  logic                    sample_valid;

  modport master (
    output aud_smp, aud_vol, aud_mask,
    input  chan_ack, ldatasum, rdatasum, sample_valid
  );

  modport slave (
    input  aud_smp, aud_vol, aud_mask,
    output chan_ack, ldatasum, rdatasum, sample_valid
  );

endinterface

// File: rtl/paula_audio_volmul.sv
// Combinational signed-sample by saturated-volume multiplier with channel mask.
module paula_audio_volmul
  import paula_audio_pkg::*;
(
  input  logic signed [SMP_W-1:0] smp_i,
  input  logic [VOL_W-1:0]        vol_i,
  input  logic                    en_i,
  output logic signed [MIX_W-1:0] prod_c
);

  logic [VOL_W-1:0]         vol_eff;
  logic signed [PROD_W-1:0] prod_full;

  // Any volume with bit 6 set plays at full scale (64).
  always_comb begin
    vol_eff   = vol_i[VOL_W-1] ? VOL_W'(VOL_FULL) : {1'b0, vol_i[VOL_W-2:0]};
    prod_full = PROD_W'(smp_i) * PROD_W'($signed({1'b0, vol_eff}));
    prod_c    = en_i ? prod_full[MIX_W-1:0] : '0;
  end

endmodule

// File: rtl/paula_audio_mixseq.sv
// Four-channel Paula mixer: per-period snapshot, one shared multiplier
// stepped over the channels, left/right accumulation and registered mix.
module paula_audio_mixseq
  import paula_audio_pkg::*;
#(
  parameter int unsigned TICK_DIV = 16,
  parameter int unsigned CW       = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clk7_en,
  paula_audio_mixseq_if.slave  bus
);

  mix_state_e              state_q;
  logic [CW-1:0]           div_q;
  mix_snap_t               snap_q;
  logic signed [MIX_W-1:0] acc_l_q;
  logic signed [MIX_W-1:0] acc_r_q;
  logic signed [MIX_W-1:0] ldat_q;
  logic signed [MIX_W-1:0] rdat_q;
  logic                    valid_q;
  logic [NUM_CH-1:0]       ack_q;

  logic [1:0]              ch_c;
  logic signed [SMP_W-1:0] smp_c;
  logic [VOL_W-1:0]        vol_c;
  logic                    en_c;
  logic signed [MIX_W-1:0] prod_c;
  logic                    wrap_c;
  logic                    mul_c;

  // Route the snapshotted channel of the current step to the multiplier.
  always_comb begin
    ch_c   = chan_of(state_q);
    smp_c  = snap_q.smp[32'(ch_c) * SMP_W +: SMP_W];
    vol_c  = snap_q.vol[32'(ch_c) * VOL_W +: VOL_W];
    en_c   = snap_q.mask[ch_c];
    wrap_c = (div_q == CW'(TICK_DIV - 1));
    mul_c  = (state_q == ST_MUL0) || (state_q == ST_MUL1) ||
             (state_q == ST_MUL2) || (state_q == ST_MUL3);
  end

  paula_audio_volmul u_volmul (
    .smp_i  (smp_c),
    .vol_i  (vol_c),
    .en_i   (en_c),
    .prod_c (prod_c)
  );

  // Sequencer, divider and output registers; pulses clear every clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      snap_q  <= '0;
      acc_l_q <= '0;
      acc_r_q <= '0;
      ldat_q  <= '0;
      rdat_q  <= '0;
      valid_q <= 1'b0;
      ack_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      ack_q   <= '0;
      if (clk7_en) begin
        div_q <= wrap_c ? '0 : div_q + CW'(1);
        if (mul_c) begin
          if (LR_ROUTE[ch_c]) acc_l_q <= acc_l_q + prod_c;
          else                acc_r_q <= acc_r_q + prod_c;
        end
        case (state_q)
          ST_IDLE: begin
            if (wrap_c) begin
              state_q <= ST_MUL0;
              snap_q  <= '{smp: bus.aud_smp, vol: bus.aud_vol, mask: bus.aud_mask};
              acc_l_q <= '0;
              acc_r_q <= '0;
              ack_q   <= '1;
            end
          end
          ST_MUL0: state_q <= ST_MUL1;
          ST_MUL1: state_q <= ST_MUL2;
          ST_MUL2: state_q <= ST_MUL3;
          ST_MUL3: state_q <= ST_DONE;
          ST_DONE: begin
            ldat_q  <= acc_l_q;
            rdat_q  <= acc_r_q;
            valid_q <= 1'b1;
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // A period boundary while mid-sequence would silently drop a sample.
  always @(posedge clk) begin
    if (reset_n && clk7_en && wrap_c) assert (state_q == ST_IDLE);
  end

  assign bus.ldatasum     = ldat_q;
  assign bus.rdatasum     = rdat_q;
  assign bus.sample_valid = valid_q;
  assign bus.chan_ack     = ack_q;

endmodule
